decryption_reg_master: RTL and testbench
========================================

DECRYPTION_REG_MASTER -- requirements
Module: decryption_reg_master

Interface
REQ-001 Parameter: ADDR_WIDTH, 8, register address width.
REQ-002 Parameter: REG_WIDTH, 16, register data width.
REQ-003 Parameter: TIMEOUT, 15, maximum WAIT cycles for done; legal range 2..255.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  command request from host.
REQ-007 cmd_ready  output  1  master accepts command this cycle.
REQ-008 cmd_write  input  1  1 = register write, 0 = register read.
REQ-009 cmd_addr  input  ADDR_WIDTH  target register address.
REQ-010 cmd_wdata  input  REG_WIDTH  write data (ignored for reads).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  host consumes response.
REQ-013 rsp_rdata  output  REG_WIDTH  read data; 0 for writes, timeouts.
REQ-014 rsp_error  output  1  regfile reported error, or timeout.
REQ-015 rsp_timeout  output  1  no done within TIMEOUT cycles.
REQ-016 addr  output  ADDR_WIDTH  register-bus address to regfile.
REQ-017 read  output  1  register-bus read strobe.
REQ-018 write  output  1  register-bus write strobe.
REQ-019 wdata  output  REG_WIDTH  register-bus write data.
REQ-020 rdata  input  REG_WIDTH  register-bus read data.
REQ-021 done  input  1  register-bus completion, valid the cycle after strobe.
REQ-022 error  input  1  register-bus error, qualified by done.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-024 IDLE: cmd_ready=1; cmd_valid&cmd_ready at edge latches cmd_write/addr/wdata, next state ISSUE.
REQ-025 ISSUE (exactly one cycle): write=latched cmd_write, read=!latched cmd_write, addr/wdata = latched values; next state WAIT, timer cleared to 0.
REQ-026 read and write SHALL never be high simultaneously, and SHALL be high only in ISSUE.
REQ-027 WAIT: read=write=0, addr/wdata held; done=1 -> capture error into rsp_error, rdata into rsp_rdata (reads) or 0 (writes), rsp_timeout=0, next RESP.
REQ-028 WAIT without done: timer increments; at timer==TIMEOUT-1 -> rsp_rdata=0, rsp_error=1, rsp_timeout=1, next RESP.
REQ-029 RESP: rsp_valid=1, payload stable; rsp_ready at edge -> IDLE; otherwise hold indefinitely.
REQ-030 cmd_ready SHALL be 0 in ISSUE, WAIT, RESP; no acceptance in the cycle a response is consumed.
REQ-031 Latency with compliant regfile: accept at edge k -> ISSUE cycle k+1 -> done seen cycle k+2 -> rsp_valid cycle k+3.
REQ-032 Minimum throughput SHALL be one transaction per 4 cycles.
REQ-033 done/error outside WAIT (including late done after timeout) SHALL be ignored.
REQ-034 Strobe outputs and cmd_ready SHALL decode from registered state only; no combinational path from cmd_* or done to bus outputs.
REQ-035 addr/wdata in IDLE SHALL hold last issued values (0 after reset).

Reset
REQ-036 rst_n=0 at edge: state IDLE, timer 0, latched command 0, rsp_rdata 0, rsp_error 0, rsp_timeout 0, irrespective of current state.
REQ-037 While rst_n=0: cmd_ready=0, read=0, write=0, rsp_valid=0.
REQ-038 Reset mid-transaction SHALL drop it silently; no response produced.

Verification
REQ-039 Write 0x10/0x0003 at edge k -> write=1 only in cycle k+1, addr=0x10, wdata=0x0003; rsp_valid cycle k+3, rsp_error=0, rsp_rdata=0.
REQ-040 After regfile reset, read 0x12 -> read=1 one cycle; rsp_rdata=0xFFFF, rsp_error=0, rsp_timeout=0.
REQ-041 Read 0x05 -> rsp_error=1, rsp_timeout=0.
REQ-042 done tied 0, TIMEOUT=15, accept at k -> rsp_valid cycle k+17, rsp_error=1, rsp_timeout=1, rsp_rdata=0; later done ignored.
REQ-043 rsp_ready low 5 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout; consumed -> cmd_ready=1 next cycle.
REQ-044 rst_n=0 during WAIT -> next cycle IDLE, no rsp_valid; new command then completes normally.

Source files
------------

// File: rtl/decryption_reg_master.sv
// Host-command to register-bus master: one outstanding read/write at a time,
// with a bounded wait for the regfile's done and a held response to the host.
`default_nettype none

module decryption_reg_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // host command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [REG_WIDTH-1:0]  cmd_wdata,
    // host response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    // register bus
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  read,
    output logic                  write,
    output logic [REG_WIDTH-1:0]  wdata,
    input  logic [REG_WIDTH-1:0]  rdata,
    input  logic                  done,
    input  logic                  error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Timer is 8 bits wide so the full 2..255 TIMEOUT range fits.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q,     state_d;
    logic [7:0]              timer_q,     timer_d;
    logic                    cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q,  cmd_addr_d;
    logic [REG_WIDTH-1:0]    cmd_wdata_q, cmd_wdata_d;
    logic [REG_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_error_q, rsp_error_d;
    logic                    rsp_tmo_q,   rsp_tmo_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_write_d = cmd_write;
                    cmd_addr_d  = cmd_addr;
                    cmd_wdata_d = cmd_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done on the final timer cycle still wins over the timeout.
                if (done) begin
                    rsp_error_d = error;
                    rsp_rdata_d = cmd_write_q ? '0 : rdata;
                    rsp_tmo_d   = 1'b0;
                    state_d     = RESP;
                end else if (timer_q == TMO_LAST) begin
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_tmo_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobes are pure decodes of the state register.
    assign cmd_ready   = rst_n && (state_q == IDLE);
    assign rsp_valid   = rst_n && (state_q == RESP);
    assign read        = rst_n && (state_q == ISSUE) && !cmd_write_q;
    assign write       = rst_n && (state_q == ISSUE) &&  cmd_write_q;
    assign addr        = cmd_addr_q;
    assign wdata       = cmd_wdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_decryption_reg_master.sv
// Directed bench for decryption_reg_master with a small behavioural regfile.
`default_nettype none

module tb_decryption_reg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_error, rsp_timeout;
    logic [7:0]  addr;
    logic        read, write;
    logic [15:0] wdata, rdata;
    logic        done, error;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // regfile model knobs
    logic        done_en    = 1'b1;
    logic        extra_done = 1'b0;
    logic        rf_done, rf_error;
    logic [15:0] rf_rdata;
    logic [15:0] mem [256];

    decryption_reg_master #(.ADDR_WIDTH(8), .REG_WIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .addr(addr), .read(read), .write(write), .wdata(wdata),
        .rdata(rdata), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Regfile: done one cycle after a strobe, 0x12 resets to 0xFFFF, 0x05 errors.
    always @(posedge clk) begin
        if (!rst_n) begin
            rf_done  <= 1'b0;
            rf_error <= 1'b0;
            rf_rdata <= 16'h0;
            for (int i = 0; i < 256; i++) mem[i] <= (i == 18) ? 16'hFFFF : 16'h0000;
        end else begin
            rf_done  <= (read || write) && done_en;
            rf_error <= (read || write) && (addr == 8'h05);
            rf_rdata <= read ? mem[addr] : 16'h0;
            if (write) mem[addr] <= wdata;
        end
    end
    assign done  = rf_done | extra_done;
    assign error = rf_error | extra_done;
    assign rdata = rf_rdata;

    // Called at a negedge with the DUT idle; returns at the negedge of the ISSUE cycle.
    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33;
        cmd_wdata = 16'h1234; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
        n_chk++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL rst_strobes got r=%b w=%b exp 0 0", read, write); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        cmd_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready got %b exp 1", cmd_ready); end
        n_chk++; if (addr !== 8'h00 || wdata !== 16'h0) begin n_fail++; $display("FAIL post_rst_bus got addr=%h wdata=%h exp 00 0000", addr, wdata); end
        n_chk++; if (rsp_rdata !== 16'h0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_rsp got rdata=%h err=%b tmo=%b exp 0000 0 0", rsp_rdata, rsp_error, rsp_timeout); end
        n_chk++; if (rsp_valid !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_idle got v=%b r=%b w=%b exp 0 0 0", rsp_valid, read, write); end
    endtask

    task automatic test_write();
        send_cmd(1'b1, 8'h10, 16'h0003);
        n_chk++; if (write !== 1'b1 || read !== 1'b0) begin n_fail++; $display("FAIL wr_issue_strobes got r=%b w=%b exp 0 1", read, write); end
        n_chk++; if (addr !== 8'h10 || wdata !== 16'h0003) begin n_fail++; $display("FAIL wr_issue_bus got addr=%h wdata=%h exp 10 0003", addr, wdata); end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_issue_cmd_ready got %b exp 0", cmd_ready); end
        @(negedge clk);
        n_chk++; if (write !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_wait got w=%b v=%b exp 0 0", write, rsp_valid); end
        n_chk++; if (addr !== 8'h10 || wdata !== 16'h0003) begin n_fail++; $display("FAIL wr_wait_bus got addr=%h wdata=%h exp 10 0003", addr, wdata); end
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid got %b exp 1", rsp_valid); end
        n_chk++; if (rsp_rdata !== 16'h0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp_payload got rdata=%h err=%b tmo=%b exp 0000 0 0", rsp_rdata, rsp_error, rsp_timeout); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_chk++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_consumed got v=%b rdy=%b exp 0 1", rsp_valid, cmd_ready); end
        n_chk++; if (addr !== 8'h10 || wdata !== 16'h0003) begin n_fail++; $display("FAIL idle_hold_bus got addr=%h wdata=%h exp 10 0003", addr, wdata); end
    endtask

    task automatic test_read();
        send_cmd(1'b0, 8'h12, 16'h5555);
        n_chk++; if (read !== 1'b1 || write !== 1'b0 || addr !== 8'h12) begin
            n_fail++; $display("FAIL rd_issue got r=%b w=%b addr=%h exp 1 0 12", read, write, addr); end
        @(negedge clk);
        n_chk++; if (read !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_one_cycle got %b exp 0", read); end
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL rd_rsp got v=%b rdata=%h exp 1 ffff", rsp_valid, rsp_rdata); end
        n_chk++; if (rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_flags got err=%b tmo=%b exp 0 0", rsp_error, rsp_timeout); end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_error();
        send_cmd(1'b0, 8'h05, 16'h0);
        repeat (2) @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL err_rsp got v=%b err=%b tmo=%b exp 1 1 0", rsp_valid, rsp_error, rsp_timeout); end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send_cmd(1'b0, 8'h10, 16'h0);
        repeat (2) @(negedge clk);
        // A competing command must not be accepted while the response waits.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h77; cmd_wdata = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0003 || rsp_error !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b rdata=%h err=%b exp 1 0003 0", i, rsp_valid, rsp_rdata, rsp_error); end
            n_chk++; if (cmd_ready !== 1'b0 || write !== 1'b0) begin
                n_fail++; $display("FAIL bp_no_accept[%0d] got rdy=%b w=%b exp 0 0", i, cmd_ready, write); end
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        n_chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || write !== 1'b0) begin
            n_fail++; $display("FAIL bp_consumed got rdy=%b v=%b w=%b exp 1 0 0", cmd_ready, rsp_valid, write); end
        n_chk++; if (addr !== 8'h10) begin n_fail++; $display("FAIL bp_no_latch got addr=%h exp 10", addr); end
    endtask

    task automatic test_timeout();
        int n;
        done_en = 1'b0;
        send_cmd(1'b0, 8'h12, 16'h0);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        n_chk++; if (n != 17) begin n_fail++; $display("FAIL tmo_latency got cycle k+%0d exp k+17", n); end
        n_chk++; if (rsp_error !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 16'h0) begin
            n_fail++; $display("FAIL tmo_payload got err=%b tmo=%b rdata=%h exp 1 1 0000", rsp_error, rsp_timeout, rsp_rdata); end
        extra_done = 1'b1; @(negedge clk); extra_done = 1'b0;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_error !== 1'b1) begin
            n_fail++; $display("FAIL tmo_late_done got v=%b tmo=%b err=%b exp 1 1 1", rsp_valid, rsp_timeout, rsp_error); end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        extra_done = 1'b1; @(negedge clk); extra_done = 1'b0;
        n_chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignore_done got rdy=%b v=%b exp 1 0", cmd_ready, rsp_valid); end
        done_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        done_en = 1'b0;
        send_cmd(1'b0, 8'h12, 16'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || read !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_held got rdy=%b v=%b r=%b exp 0 0 0", cmd_ready, rsp_valid, read); end
        rst_n = 1'b1; done_en = 1'b1;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || addr !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst_idle got rdy=%b v=%b addr=%h exp 1 0 00", cmd_ready, rsp_valid, addr); end
        send_cmd(1'b1, 8'h20, 16'hABCD);
        repeat (2) @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_recover got v=%b err=%b tmo=%b exp 1 0 0", rsp_valid, rsp_error, rsp_timeout); end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a   [3] = '{8'h20, 8'h12, 8'h05};
        logic [15:0] exd [3] = '{16'hABCD, 16'hFFFF, 16'h0000};
        logic        exe [3] = '{1'b0, 1'b0, 1'b1};
        int t_prev, t_now;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            t_now = cyc;
            send_cmd(1'b0, a[i], 16'h0);
            if (i > 0) begin
                n_chk++; if (t_now - t_prev != 4) begin n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 4", i, t_now - t_prev); end
            end
            t_prev = t_now;
            n_chk++; if (read !== 1'b1 || addr !== a[i]) begin n_fail++; $display("FAIL b2b_issue[%0d] got r=%b addr=%h exp 1 %h", i, read, addr, a[i]); end
            repeat (2) @(negedge clk);
            n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== exd[i] || rsp_error !== exe[i]) begin
                n_fail++; $display("FAIL b2b_rsp[%0d] got v=%b rdata=%h err=%b exp 1 %h %b", i, rsp_valid, rsp_rdata, rsp_error, exd[i], exe[i]); end
            rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
            n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, cmd_ready); end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0;
        cmd_wdata = 16'h0; rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_error();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
